// File: rtl/mem_arbiter_ctlr.sv
// Arbitrates dcache and icache bus commands onto single-ported memory and routes
// tagged returns back to the client that owns each outstanding tag.
module mem_arbiter_ctlr #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned XLEN         = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       dcache2ctlr_command,
    input  logic [XLEN-1:0]  dcache2ctlr_addr,
    input  logic [63:0]      dcache2ctlr_data,
    input  logic [1:0]       icache2ctlr_command,
    input  logic [XLEN-1:0]  icache2ctlr_addr,
    output logic [1:0]       ctlr2mem_command,
    output logic [XLEN-1:0]  ctlr2mem_addr,
    output logic [63:0]      ctlr2mem_data,
    input  logic [TAG_W-1:0] mem2ctlr_response,
    input  logic [63:0]      mem2ctlr_data,
    input  logic [TAG_W-1:0] mem2ctlr_tag,
    output logic [TAG_W-1:0] ctlr2dcache_response,
    output logic [63:0]      ctlr2dcache_data,
    output logic [TAG_W-1:0] ctlr2dcache_tag,
    output logic [TAG_W-1:0] ctlr2icache_response,
    output logic [63:0]      ctlr2icache_data,
    output logic [TAG_W-1:0] ctlr2icache_tag,
    output logic             ctlr_err
);

    localparam int unsigned NUM_TAGS = 1 << TAG_W;
    localparam logic [1:0]  BUS_NONE = 2'd0;
    localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

    // Entry 0 is never allocated since a zero response means "not accepted".
    logic [NUM_TAGS-1:0] owner_valid;
    logic [NUM_TAGS-1:0] owner_is_icache;
    logic [3:0]          starve_cnt;
    logic                err_flag;

    logic dcache_req, icache_req, forced;
    logic grant_icache, grant_dcache, accepted, icache_accepted;
    logic ret_valid, ret_icache, ret_orphan;

    always_comb begin
        dcache_req      = dcache2ctlr_command != BUS_NONE;
        icache_req      = icache2ctlr_command != BUS_NONE;
        forced          = icache_req && (starve_cnt == LIMIT);
        grant_icache    = icache_req && (forced || !dcache_req);
        grant_dcache    = dcache_req && !grant_icache;
        accepted        = mem2ctlr_response != '0;
        icache_accepted = grant_icache && accepted;
        ret_valid       = (mem2ctlr_tag != '0) && owner_valid[mem2ctlr_tag];
        ret_icache      = owner_is_icache[mem2ctlr_tag];
        ret_orphan      = (mem2ctlr_tag != '0) && !owner_valid[mem2ctlr_tag];
    end

    always_comb begin
        ctlr2mem_command     = BUS_NONE;
        ctlr2mem_addr        = '0;
        ctlr2mem_data        = '0;
        ctlr2dcache_response = '0;
        ctlr2dcache_data     = '0;
        ctlr2dcache_tag      = '0;
        ctlr2icache_response = '0;
        ctlr2icache_data     = '0;
        ctlr2icache_tag      = '0;
        ctlr_err             = err_flag && !reset;
        if (!reset) begin
            if (grant_icache) begin
                ctlr2mem_command     = icache2ctlr_command;
                ctlr2mem_addr        = icache2ctlr_addr;
                ctlr2icache_response = mem2ctlr_response;
            end else if (grant_dcache) begin
                ctlr2mem_command     = dcache2ctlr_command;
                ctlr2mem_addr        = dcache2ctlr_addr;
                ctlr2mem_data        = dcache2ctlr_data;
                ctlr2dcache_response = mem2ctlr_response;
            end
            if (ret_valid) begin
                if (ret_icache) begin
                    ctlr2icache_tag  = mem2ctlr_tag;
                    ctlr2icache_data = mem2ctlr_data;
                end else begin
                    ctlr2dcache_tag  = mem2ctlr_tag;
                    ctlr2dcache_data = mem2ctlr_data;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_valid     <= '0;
            owner_is_icache <= '0;
            starve_cnt      <= '0;
            err_flag        <= 1'b0;
        end else begin
            if (ret_valid) begin
                owner_valid[mem2ctlr_tag] <= 1'b0;
            end
            if (ret_orphan) begin
                err_flag <= 1'b1;
            end
            // Placed after the release so a same-tag allocate takes precedence.
            if (accepted && (grant_icache || grant_dcache)) begin
                owner_valid[mem2ctlr_response]     <= 1'b1;
                owner_is_icache[mem2ctlr_response] <= grant_icache;
            end
            if (!icache_req || icache_accepted) begin
                starve_cnt <= '0;
            end else if (starve_cnt < LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctlr.sv
// Directed bench for mem_arbiter_ctlr: grant priority, tag routing, starvation
// override and orphan-return error flag.
module tb_mem_arbiter_ctlr;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  d_cmd, i_cmd, m_cmd;
    logic [31:0] d_addr, i_addr, m_addr;
    logic [63:0] d_data, m_data, mem_data, dc_data, ic_data;
    logic [3:0]  mem_resp, mem_tag, dc_resp, dc_tag, ic_resp, ic_tag;
    logic        err;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    mem_arbiter_ctlr #(.STARVE_LIMIT(4), .TAG_W(4), .XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .dcache2ctlr_command(d_cmd), .dcache2ctlr_addr(d_addr), .dcache2ctlr_data(d_data),
        .icache2ctlr_command(i_cmd), .icache2ctlr_addr(i_addr),
        .ctlr2mem_command(m_cmd), .ctlr2mem_addr(m_addr), .ctlr2mem_data(m_data),
        .mem2ctlr_response(mem_resp), .mem2ctlr_data(mem_data), .mem2ctlr_tag(mem_tag),
        .ctlr2dcache_response(dc_resp), .ctlr2dcache_data(dc_data), .ctlr2dcache_tag(dc_tag),
        .ctlr2icache_response(ic_resp), .ctlr2icache_data(ic_data), .ctlr2icache_tag(ic_tag),
        .ctlr_err(err)
    );

    // Advance one cycle; inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        d_cmd = 2'd0; d_addr = '0; d_data = '0;
        i_cmd = 2'd0; i_addr = '0;
        mem_resp = '0; mem_data = '0; mem_tag = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        d_cmd = 2'd1; d_addr = 32'h40; mem_resp = 4'd2; mem_tag = 4'd9; mem_data = 64'h55;
        tick();
        #1;
        total++;
        if (m_cmd !== 2'd0 || dc_resp !== 4'd0 || dc_tag !== 4'd0 || dc_data !== 64'd0)
            $display("FAIL reset_gate: cmd=%0d dresp=%0d dtag=%0d want 0", m_cmd, dc_resp, dc_tag);
        else passed++;
        idle();
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({m_cmd, m_addr, m_data, dc_resp, dc_tag, dc_data, ic_resp, ic_tag, ic_data, err} !== '0)
            $display("FAIL reset_idle: cmd=%0d addr=%h err=%b want all 0", m_cmd, m_addr, err);
        else passed++;
    endtask

    task automatic test_basic_route();
        do_reset();
        d_cmd = 2'd1; d_addr = 32'h100; i_cmd = 2'd1; i_addr = 32'h200; mem_resp = 4'd3;
        #1;
        total++;
        if (m_cmd !== 2'd1 || m_addr !== 32'h100 || dc_resp !== 4'd3 || ic_resp !== 4'd0)
            $display("FAIL basic_grant: cmd=%0d addr=%h dresp=%0d iresp=%0d want 1 100 3 0",
                     m_cmd, m_addr, dc_resp, ic_resp);
        else passed++;
        tick();
        idle();
        tick();
        mem_tag = 4'd3; mem_data = 64'hDEADBEEF_CAFEF00D;
        #1;
        total++;
        if (dc_tag !== 4'd3 || dc_data !== 64'hDEADBEEF_CAFEF00D || ic_tag !== 4'd0 || ic_data !== 64'd0)
            $display("FAIL basic_return: dtag=%0d ddata=%h itag=%0d idata=%h want 3 deadbeefcafef00d 0 0",
                     dc_tag, dc_data, ic_tag, ic_data);
        else passed++;
        tick();
        #1;
        total++;
        if (dc_tag !== 4'd0 || ic_tag !== 4'd0)
            $display("FAIL basic_cleared: dtag=%0d itag=%0d want 0 0", dc_tag, ic_tag);
        else passed++;
        tick();
        idle();
        #1;
        total++;
        if (err !== 1'b1)
            $display("FAIL basic_reuse_err: err=%b want 1", err);
        else passed++;
    endtask

    task automatic test_starve();
        do_reset();
        d_cmd = 2'd2; d_addr = 32'h300; d_data = 64'h1234;
        i_cmd = 2'd1; i_addr = 32'h400; mem_resp = 4'd1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total++;
            if (m_addr !== 32'h300 || m_data !== 64'h1234 || dc_resp !== 4'd1 || ic_resp !== 4'd0)
                $display("FAIL starve_dgrant%0d: addr=%h dresp=%0d iresp=%0d want 300 1 0",
                         c, m_addr, dc_resp, ic_resp);
            else passed++;
            tick();
        end
        #1;
        total++;
        if (m_addr !== 32'h400 || m_cmd !== 2'd1 || m_data !== 64'd0 || ic_resp !== 4'd1 || dc_resp !== 4'd0)
            $display("FAIL starve_force: addr=%h cmd=%0d data=%h iresp=%0d dresp=%0d want 400 1 0 1 0",
                     m_addr, m_cmd, m_data, ic_resp, dc_resp);
        else passed++;
        tick();
        #1;
        total++;
        if (m_addr !== 32'h300 || ic_resp !== 4'd0)
            $display("FAIL starve_reset_cnt: addr=%h iresp=%0d want 300 0", m_addr, ic_resp);
        else passed++;
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        d_cmd = 2'd1; d_addr = 32'h500; i_cmd = 2'd1; i_addr = 32'h600; mem_resp = 4'd2;
        for (int c = 0; c < 4; c++) tick();
        mem_resp = 4'd0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            total++;
            if (m_addr !== 32'h600 || dc_resp !== 4'd0 || ic_resp !== 4'd0)
                $display("FAIL bp_hold%0d: addr=%h dresp=%0d iresp=%0d want 600 0 0",
                         c, m_addr, dc_resp, ic_resp);
            else passed++;
            tick();
        end
        mem_resp = 4'd2;
        #1;
        total++;
        if (m_addr !== 32'h600 || ic_resp !== 4'd2 || dc_resp !== 4'd0)
            $display("FAIL bp_accept: addr=%h iresp=%0d dresp=%0d want 600 2 0", m_addr, ic_resp, dc_resp);
        else passed++;
        tick();
        #1;
        total++;
        if (m_addr !== 32'h500 || dc_resp !== 4'd2)
            $display("FAIL bp_after: addr=%h dresp=%0d want 500 2", m_addr, dc_resp);
        else passed++;
        idle();
    endtask

    task automatic test_orphan_err();
        do_reset();
        mem_tag = 4'd5; mem_data = 64'hABCD;
        #1;
        total++;
        if (dc_tag !== 4'd0 || ic_tag !== 4'd0 || dc_data !== 64'd0 || ic_data !== 64'd0 || err !== 1'b0)
            $display("FAIL orphan_drop: dtag=%0d itag=%0d err=%b want 0 0 0", dc_tag, ic_tag, err);
        else passed++;
        tick();
        idle();
        tick();
        tick();
        #1;
        total++;
        if (err !== 1'b1)
            $display("FAIL orphan_sticky: err=%b want 1", err);
        else passed++;
        do_reset();
        #1;
        total++;
        if (err !== 1'b0)
            $display("FAIL orphan_clear: err=%b want 0", err);
        else passed++;
    endtask

    task automatic test_same_tag();
        do_reset();
        i_cmd = 2'd1; i_addr = 32'h700; mem_resp = 4'd7;
        #1;
        total++;
        if (ic_resp !== 4'd7)
            $display("FAIL same_alloc: iresp=%0d want 7", ic_resp);
        else passed++;
        tick();
        idle();
        d_cmd = 2'd2; d_addr = 32'h800; d_data = 64'h77; mem_resp = 4'd7;
        mem_tag = 4'd7; mem_data = 64'hAAAA_0001;
        #1;
        total++;
        if (ic_tag !== 4'd7 || ic_data !== 64'hAAAA_0001 || dc_tag !== 4'd0 || dc_resp !== 4'd7)
            $display("FAIL same_old_owner: itag=%0d idata=%h dtag=%0d dresp=%0d want 7 aaaa0001 0 7",
                     ic_tag, ic_data, dc_tag, dc_resp);
        else passed++;
        tick();
        idle();
        tick();
        mem_tag = 4'd7; mem_data = 64'hBBBB_0002;
        #1;
        total++;
        if (dc_tag !== 4'd7 || dc_data !== 64'hBBBB_0002 || ic_tag !== 4'd0 || ic_data !== 64'd0)
            $display("FAIL same_new_owner: dtag=%0d ddata=%h itag=%0d want 7 bbbb0002 0",
                     dc_tag, dc_data, ic_tag);
        else passed++;
        tick();
        idle();
        #1;
        total++;
        if (err !== 1'b0)
            $display("FAIL same_no_err: err=%b want 0", err);
        else passed++;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_basic_route();
        test_starve();
        test_backpressure();
        test_orphan_err();
        test_same_tag();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
